qk_tile_scheduler: RTL

//  Issue engine for the Qn*KnT stage of the self-attention head, generalised to NUM_HEADS heads.

---
 rtl/qk_tile_scheduler_if.sv | 25 ++
 rtl/qk_tile_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/qk_tile_scheduler_if.sv
// Issue-beat bus from qk_tile_scheduler (master) to the matmul cores (slave).
// One beat carries a Q tile address, a K tile address, the head index and
// the accumulate-first/last flags, qualified by issue_valid/issue_ready.
interface qk_tile_scheduler_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int HEAD_W     = 2
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic [ADDR_WIDTH-1:0] k_addr;
  logic [HEAD_W-1:0]     head_idx;
  logic                  acc_first;
  logic                  acc_last;

  modport master (
    output issue_valid, q_addr, k_addr, head_idx, acc_first, acc_last,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, q_addr, k_addr, head_idx, acc_first, acc_last,
    output issue_ready
  );
endinterface

// File: rtl/qk_tile_scheduler.sv
// Issue engine for the Qn*KnT stage of a multi-head self-attention block.
// Walks head -> A tile -> B tile -> inner (k) tile as an odometer and emits
// one registered (q_addr, k_addr) beat per valid/ready handshake, then
// pulses done for one cycle.
// Optional feature macro: QK_CAUSAL_SKIP_EN -- skip (a,b) tile pairs lying
// wholly above the diagonal (causal mask); default build issues every pair.
module qk_tile_scheduler #(
  parameter int NUM_HEADS   = 2,
  parameter int A_OUTER_DIM = 16,
  parameter int INNER_DIM   = 8,
  parameter int BLOCK_SIZE  = 2,
  parameter int NUM_CORES_A = 2,
  parameter int NUM_CORES_B = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  qk_tile_scheduler_if.master issue
);

  localparam int A_TILES = A_OUTER_DIM / (BLOCK_SIZE * NUM_CORES_A);
  localparam int B_TILES = A_OUTER_DIM / (BLOCK_SIZE * NUM_CORES_B);
  localparam int K_TILES = INNER_DIM / BLOCK_SIZE;
  localparam int HEAD_W  = $clog2(NUM_HEADS) + 1;
  localparam int A_W     = (A_TILES > 1) ? $clog2(A_TILES) : 1;
  localparam int B_W     = (B_TILES > 1) ? $clog2(B_TILES) : 1;
  localparam int K_W     = (K_TILES > 1) ? $clog2(K_TILES) : 1;

  if ((A_OUTER_DIM % (BLOCK_SIZE * NUM_CORES_A)) != 0 ||
      (A_OUTER_DIM % (BLOCK_SIZE * NUM_CORES_B)) != 0 ||
      (INNER_DIM % BLOCK_SIZE) != 0) begin : g_inexact_div
    $error("qk_tile_scheduler: tile divisions must be exact");
  end

  if (longint'(NUM_HEADS) * A_TILES * K_TILES >= (longint'(1) << ADDR_WIDTH) ||
      longint'(NUM_HEADS) * B_TILES * K_TILES >= (longint'(1) << ADDR_WIDTH)) begin : g_addr_overflow
    $error("qk_tile_scheduler: ADDR_WIDTH too small for the tile address space");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] q_addr;
    logic [ADDR_WIDTH-1:0] k_addr;
    logic [HEAD_W-1:0]     head_idx;
    logic                  acc_first;
    logic                  acc_last;
  } beat_t;

  state_e            state_q, state_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [A_W-1:0]    a_q, a_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [K_W-1:0]    k_q, k_d;
  beat_t             beat_q, beat_d;

  logic fire;
  logic k_last, b_last, a_last, head_last;

  assign fire      = (state_q == S_RUN) && issue.issue_ready;
  assign k_last    = (int'(k_q) == K_TILES - 1);
  assign a_last    = (int'(a_q) == A_TILES - 1);
  assign head_last = (int'(head_q) == NUM_HEADS - 1);

`ifdef QK_CAUSAL_SKIP_EN
  // The B row ends early once the next B tile starts past the last A row.
  assign b_last = (int'(b_q) + 1 >= B_TILES) ||
                  ((int'(b_q) + 1) * NUM_CORES_B * BLOCK_SIZE >
                   (int'(a_q) + 1) * NUM_CORES_A * BLOCK_SIZE - 1);
`else
  assign b_last = (int'(b_q) == B_TILES - 1);
`endif

  // Next-state and odometer advance; a counter only moves on a handshake.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (fire) begin
          if (!k_last) begin
            k_d = k_q + K_W'(1);
          end else begin
            k_d = '0;
            if (!b_last) begin
              b_d = b_q + B_W'(1);
            end else begin
              b_d = '0;
              if (!a_last) begin
                a_d = a_q + A_W'(1);
              end else begin
                a_d = '0;
                if (!head_last) begin
                  head_d = head_q + HEAD_W'(1);
                end else begin
                  head_d  = '0;
                  state_d = S_DONE;
                end
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Payload for the beat that will be on the bus next cycle (zero outside RUN).
  always_comb begin
    beat_d = '0;
    if (state_d == S_RUN) begin
      beat_d.q_addr    = ADDR_WIDTH'(int'(head_d) * A_TILES * K_TILES +
                                     int'(a_d) * K_TILES + int'(k_d));
      beat_d.k_addr    = ADDR_WIDTH'(int'(head_d) * B_TILES * K_TILES +
                                     int'(b_d) * K_TILES + int'(k_d));
      beat_d.head_idx  = head_d;
      beat_d.acc_first = (k_d == '0);
      beat_d.acc_last  = (int'(k_d) == K_TILES - 1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Tile counters and registered beat payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      beat_q <= '0;
    end else begin
      head_q <= head_d;
      a_q    <= a_d;
      b_q    <= b_d;
      k_q    <= k_d;
      beat_q <= beat_d;
    end
  end

  assign busy              = (state_q == S_RUN);
  assign done              = (state_q == S_DONE);
  assign issue.issue_valid = busy;
  assign issue.q_addr      = beat_q.q_addr;
  assign issue.k_addr      = beat_q.k_addr;
  assign issue.head_idx    = beat_q.head_idx;
  assign issue.acc_first   = beat_q.acc_first;
  assign issue.acc_last    = beat_q.acc_last;

endmodule
